// File: rtl/n_bit_adder.sv
// Registered N-bit ripple-carry adder: {c_out, S} <= A + B + c_in, one cycle of latency.
// Define N_ADDER_FLAGS_EN to add the registered ovf and zero flags.

module n_bit_adder_fa (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic p;

  assign p     = a ^ b;
  assign s     = p ^ c_in;
  assign c_out = (a & b) | (c_in & p);

endmodule

module n_bit_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         c_in,
  output logic [N-1:0] S,
  output logic         c_out
`ifdef N_ADDER_FLAGS_EN
  ,
  output logic         ovf,
  output logic         zero
`endif
);

  logic [N:0]   carry;
  logic [N-1:0] s_next;

  assign carry[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_bit
    n_bit_adder_fa u_fa (
      .a     (A[i]),
      .b     (B[i]),
      .c_in  (carry[i]),
      .s     (s_next[i]),
      .c_out (carry[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S     <= '0;
      c_out <= 1'b0;
    end else begin
      S     <= s_next;
      c_out <= carry[N];
    end
  end

`ifdef N_ADDER_FLAGS_EN
  // Signed overflow shows up as disagreement between the carries into and out of the sign bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf  <= 1'b0;
      zero <= 1'b1;
    end else begin
      ovf  <= carry[N] ^ carry[N-1];
      zero <= ~|s_next;
    end
  end
`endif

endmodule

// File: tb/tb_n_bit_adder.sv
// Scoreboard bench for n_bit_adder (N=8): stimulus pushes expected results, a monitor pops and compares.
// Flag checks are active only when N_ADDER_FLAGS_EN is defined.

module tb_n_bit_adder;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] A, B, S;
  logic         c_in, c_out;
`ifdef N_ADDER_FLAGS_EN
  logic         ovf, zero;
`endif

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
    logic         ovf;
    logic         z;
  } exp_t;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    exp_t         e;
  } vec_t;

  exp_t sb_q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  n_bit_adder #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .c_in  (c_in),
    .S     (S),
    .c_out (c_out)
`ifdef N_ADDER_FLAGS_EN
    ,
    .ovf   (ovf),
    .zero  (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_out(input string name, input exp_t e);
    logic ok;
    ok = (S === e.s) && (c_out === e.c);
`ifdef N_ADDER_FLAGS_EN
    ok = ok && (ovf === e.ovf) && (zero === e.z);
    if (!ok)
      $display("FAIL %s: got S=%h c_out=%b ovf=%b zero=%b, want S=%h c_out=%b ovf=%b zero=%b",
               name, S, c_out, ovf, zero, e.s, e.c, e.ovf, e.z);
`else
    if (!ok)
      $display("FAIL %s: got S=%h c_out=%b, want S=%h c_out=%b", name, S, c_out, e.s, e.c);
`endif
    cmp_cnt++;
    if (!ok) err_cnt++;
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
    exp_t    r;
    logic [N:0] sum;
    sum   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    r.s   = sum[N-1:0];
    r.c   = sum[N];
    r.ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
    r.z   = (sum[N-1:0] == '0);
    return r;
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    A    = v.a;
    B    = v.b;
    c_in = v.cin;
    sb_q.push_back(v.e);
  endtask

  // Monitor: any expectation queued before this edge belongs to the value captured at it.
  always @(posedge clk) begin
    exp_t e;
    if (!rst && sb_q.size() > 0) begin
      #1;
      e = sb_q.pop_front();
      check_out("scoreboard", e);
    end
  end

  localparam exp_t RESET_EXP = '{s: '0, c: 1'b0, ovf: 1'b0, z: 1'b1};

  vec_t dir_tbl[6];

  initial begin
    vec_t v;
    dir_tbl[0] = '{a: 8'd5,   b: 8'd10,  cin: 1'b0, e: '{s: 8'd15,  c: 1'b0, ovf: 1'b0, z: 1'b0}};
    dir_tbl[1] = '{a: 8'd5,   b: 8'd10,  cin: 1'b1, e: '{s: 8'd16,  c: 1'b0, ovf: 1'b0, z: 1'b0}};
    dir_tbl[2] = '{a: 8'd30,  b: 8'd246, cin: 1'b0, e: '{s: 8'd20,  c: 1'b1, ovf: 1'b0, z: 1'b0}};
    dir_tbl[3] = '{a: 8'd127, b: 8'd1,   cin: 1'b0, e: '{s: 8'h80,  c: 1'b0, ovf: 1'b1, z: 1'b0}};
    dir_tbl[4] = '{a: 8'hFF,  b: 8'h00,  cin: 1'b1, e: '{s: 8'h00,  c: 1'b1, ovf: 1'b0, z: 1'b1}};
    dir_tbl[5] = '{a: 8'hFF,  b: 8'hFF,  cin: 1'b1, e: '{s: 8'hFF,  c: 1'b1, ovf: 1'b0, z: 1'b0}};

    rst  = 1'b1;
    A    = 8'd5;
    B    = 8'd10;
    c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_hold", RESET_EXP);

    // Release reset with inputs held: the next edge captures 5+10.
    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back('{s: 8'd15, c: 1'b0, ovf: 1'b0, z: 1'b0});

    foreach (dir_tbl[i]) drive(dir_tbl[i]);

    // Reset after a result has landed: outputs clear at once, between edges.
    v.a = 8'd200; v.b = 8'd100; v.cin = 1'b1;
    v.e = '{s: 8'd45, c: 1'b1, ovf: 1'b0, z: 1'b0};
    drive(v);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst_clear", RESET_EXP);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      v.a   = 8'($urandom);
      v.b   = 8'($urandom);
      v.cin = 1'($urandom);
      v.e   = model(v.a, v.b, v.cin);
      drive(v);
      if (i == 5) begin
        // Short pulse before the capturing edge; the edge after release samples normally.
        #1;
        rst = 1'b1;
        #1;
        check_out("rst_pulse_midstream", RESET_EXP);
        #1;
        rst = 1'b0;
      end
    end

    begin
      int budget;
      budget = 5;
      while (sb_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      if (sb_q.size() > 0) begin
        $display("FAIL drain: %0d results still pending, want 0", sb_q.size());
        cmp_cnt++;
        err_cnt++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
